// File: rtl/fetch_stage_pkg.sv
// Shared parameters and types for the instruction fetch stage.
package fetch_stage_pkg;

   typedef logic [31:0] word;

   typedef enum logic {
      BRANCH_DISABLE = 1'b0,
      BRANCH_ENABLE  = 1'b1
   } branch_en_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      word pc;
      word inst;
   } fetch_entry_t;

   localparam int FETCH_DEPTH = 2;

   // Clear the two low address bits (word alignment).
   function automatic word align_word(input word addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, inst} buffer between instruction memory and decode.
// Clear and rst both empty it; push while full is accepted only with a pop.
module fetch_fifo
   import fetch_stage_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic push,
   input  logic pop,
   input  word  push_pc,
   input  word  push_inst,
   output word  head_pc,
   output word  head_inst,
   output logic full,
   output logic empty
);

   localparam logic [1:0] DEPTH_C = 2'(FETCH_DEPTH);

   fetch_entry_t mem_r [FETCH_DEPTH];
   logic         rd_ptr_r;
   logic         wr_ptr_r;
   logic [1:0]   count_r;
   logic         push_ok_s;
   logic         pop_ok_s;

   assign full      = (count_r == DEPTH_C);
   assign empty     = (count_r == 2'd0);
   assign pop_ok_s  = pop & ~empty;
   assign push_ok_s = push & (~full | pop_ok_s);
   assign head_pc   = mem_r[rd_ptr_r].pc;
   assign head_inst = mem_r[rd_ptr_r].inst;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr_r <= 1'b0;
         wr_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
      end
   end

   // Entry storage; contents need no reset because occupancy gates them.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= '{pc: push_pc, inst: push_inst};
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential requests, buffers in-order
// responses with their PCs, and handles redirects by discarding in-flight
// responses. Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned
// redirect targets into HALT; without it the target is word-aligned.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter word RESET_PC = 32'h0000_0000
)
(
   input  logic       clk,
   input  logic       rst,
   input  branch_en_t branch_scs,
   input  word        branch_target,
   output logic       imem_req_valid,
   input  logic       imem_req_ready,
   output word        imem_addr,
   input  logic       imem_rsp_valid,
   input  word        imem_rsp_data,
   output logic       inst_valid,
   input  logic       inst_ready,
   output word        inst,
   output word        inst_pc,
   output logic       misalign
);

   fetch_state_t state_r, state_s;
   word          pc_r, pc_s, target_s;
   logic [1:0]   outstanding_r, out_next_s;
   logic [1:0]   drop_count_r, drop_s, drop_dec_s;
   logic [1:0]   buffered_s;
   logic [2:0]   occ_s;
   logic         redirect_s, rsp_take_s, handshake_s, pop_s, push_s, clear_s;
   logic         full_s, empty_s, req_valid_s;
   word          head_pc_s, head_inst_s;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic         misalign_r, misalign_s, misaligned_s;
   assign target_s     = branch_target;
   assign misaligned_s = |branch_target[1:0];
   assign misalign     = misalign_r & ~rst;
`else
   assign target_s     = align_word(branch_target);
   assign misalign     = 1'b0;
`endif

   assign redirect_s  = (branch_scs == BRANCH_ENABLE);
   assign rsp_take_s  = imem_rsp_valid & (outstanding_r != 2'd0);
   assign buffered_s  = full_s ? 2'd2 : (empty_s ? 2'd0 : 2'd1);
   assign inst_valid  = ~empty_s & ~rst;
   assign pop_s       = inst_valid & inst_ready;
   assign occ_s       = {1'b0, outstanding_r} + {1'b0, buffered_s} - {2'b00, pop_s};
   assign handshake_s = req_valid_s & imem_req_ready;
   assign out_next_s  = outstanding_r + {1'b0, handshake_s} - {1'b0, rsp_take_s};
   assign drop_dec_s  = (rsp_take_s && (drop_count_r != 2'd0)) ? (drop_count_r - 2'd1) : drop_count_r;

   assign imem_req_valid = req_valid_s;
   assign imem_addr      = pc_r;
   assign inst           = head_inst_s;
   assign inst_pc        = head_pc_s;

   // Request valid: fetching, no redirect, and room once this cycle's pop is credited.
   always_comb begin
      req_valid_s = 1'b0;
      if ((state_r == FETCH) && !redirect_s && !rst) begin
         req_valid_s = (occ_s < 3'd2);
      end else begin
         req_valid_s = 1'b0;
      end
   end

   // Next-state, PC, drop count and buffer control.
   always_comb begin
      state_s = state_r;
      pc_s    = handshake_s ? (pc_r + 32'd4) : pc_r;
      drop_s  = drop_count_r;
      push_s  = 1'b0;
      clear_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_s = 1'b0;
`endif
      case (state_r)
         FETCH: begin
            if (redirect_s) begin
               pc_s    = target_s;
               clear_s = 1'b1;
               drop_s  = out_next_s;
               state_s = (out_next_s != 2'd0) ? FLUSH : FETCH;
            end else begin
               push_s  = rsp_take_s;
            end
         end
         FLUSH: begin
            drop_s  = drop_dec_s;
            clear_s = 1'b1;
            if (redirect_s) begin
               pc_s = target_s;
            end else begin
               pc_s = pc_r;
            end
            state_s = (drop_dec_s != 2'd0) ? FLUSH : FETCH;
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         HALT: begin
            drop_s  = drop_dec_s;
            clear_s = 1'b1;
            if (redirect_s) begin
               pc_s    = target_s;
               state_s = (drop_dec_s != 2'd0) ? FLUSH : FETCH;
            end else begin
               state_s = HALT;
            end
         end
`endif
         default: begin
            state_s = FETCH;
            clear_s = 1'b1;
            drop_s  = out_next_s;
         end
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_s && misaligned_s) begin
         state_s    = HALT;
         clear_s    = 1'b1;
         push_s     = 1'b0;
         misalign_s = 1'b1;
      end else begin
         misalign_s = 1'b0;
      end
`endif
   end

   // Architectural state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= FETCH;
         pc_r          <= RESET_PC;
         outstanding_r <= 2'd0;
         drop_count_r  <= 2'd0;
      end else begin
         state_r       <= state_s;
         pc_r          <= pc_s;
         outstanding_r <= out_next_s;
         drop_count_r  <= drop_s;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // One-cycle misalign pulse following a misaligned redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_r <= 1'b0;
      end else begin
         misalign_r <= misalign_s;
      end
   end
`endif

   fetch_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_s),
      .push      (push_s),
      .pop       (pop_s),
      .push_pc   (pc_r - (32'd4 * {30'd0, outstanding_r}) + 32'd0),
      .push_inst (imem_rsp_data),
      .head_pc   (head_pc_s),
      .head_inst (head_inst_s),
      .full      (full_s),
      .empty     (empty_s)
   );

endmodule
